// File: rtl/dcache_port_arbiter_if.sv
// Request/response bundle for one side of a DCache request port.
// A requester (or the arbiter facing the cache) drives through master; the receiving side uses slave.
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              read_mem;
    logic              write_mem;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [DATA_W-1:0] write_data;
    logic              write_data_valid;
    logic              mem_done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output read_mem, write_mem, addr, addr_valid, write_data, write_data_valid,
        input  mem_done, rdata
    );

    modport slave (
        input  read_mem, write_mem, addr, addr_valid, write_data, write_data_valid,
        output mem_done, rdata
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares the single DCache request port between the LSU and the DMA engine, one transaction in flight.
// LSU has priority; a saturating starvation counter forces a DMA win after STARVE_LIMIT contested LSU grants.
module dcache_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dcache_port_arbiter_if.slave          lsu,
    dcache_port_arbiter_if.slave          dma,
    dcache_port_arbiter_if.master         dcache,
    output logic                          gnt_lsu,
    output logic                          gnt_dma
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_LSU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic                is_write_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;

    logic                capture;
    logic                pick_dma;
    logic                starve_full;

    // Index 0 = LSU, index 1 = DMA
    logic [1:0] rd_in, wr_in, av_in, wdv_in, req;

    assign rd_in  = {dma.read_mem,         lsu.read_mem};
    assign wr_in  = {dma.write_mem,        lsu.write_mem};
    assign av_in  = {dma.addr_valid,       lsu.addr_valid};
    assign wdv_in = {dma.write_data_valid, lsu.write_data_valid};

    // A write (which wins over a simultaneous read) only counts once its data is valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req[gi] = av_in[gi] & (wr_in[gi] ? wdv_in[gi] : rd_in[gi]);
        end
    endgenerate

    assign starve_full = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        capture         = 1'b0;
        pick_dma        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req[0] && !(req[1] && starve_full)) begin
                    state_next = BUSY_LSU;
                    capture    = 1'b1;
                    if (req[1] && !starve_full) begin
                        starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
                    end
                end else if (req[1]) begin
                    state_next      = BUSY_DMA;
                    capture         = 1'b1;
                    pick_dma        = 1'b1;
                    starve_cnt_next = '0;
                end
            end
            BUSY_LSU, BUSY_DMA: begin
                if (dcache.mem_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            is_write_reg   <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            if (capture) begin
                is_write_reg <= wr_in[pick_dma];
                addr_reg     <= pick_dma ? dma.addr : lsu.addr;
                if (wr_in[pick_dma]) begin
                    wdata_reg <= pick_dma ? dma.write_data : lsu.write_data;
                end else begin
                    wdata_reg <= '0;
                end
            end
        end
    end

    logic busy, lsu_done, dma_done;

    assign busy     = (state_reg != IDLE);
    assign lsu_done = (state_reg == BUSY_LSU) & dcache.mem_done;
    assign dma_done = (state_reg == BUSY_DMA) & dcache.mem_done;

    // Cache-side outputs come only from captured registers, so requester changes mid-flight are invisible.
    assign dcache.read_mem         = busy & ~is_write_reg;
    assign dcache.write_mem        = busy & is_write_reg;
    assign dcache.addr             = busy ? addr_reg : '0;
    assign dcache.addr_valid       = busy;
    assign dcache.write_data       = (busy & is_write_reg) ? wdata_reg : '0;
    assign dcache.write_data_valid = busy & is_write_reg;

    assign lsu.mem_done = lsu_done;
    assign lsu.rdata    = lsu_done ? dcache.rdata : '0;
    assign dma.mem_done = dma_done;
    assign dma.rdata    = dma_done ? dcache.rdata : '0;

    assign gnt_lsu = (state_reg == BUSY_LSU);
    assign gnt_dma = (state_reg == BUSY_DMA);
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: reset, single read, starvation rotation, write gating,
// address hold, reset mid-transaction and spurious completion.
module tb_dcache_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic gnt_lsu, gnt_dma;
    int   vectors = 0;
    int   miscompares = 0;

    dcache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
    dcache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dma_bus ();
    dcache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cache_bus ();

    dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lsu     (lsu_bus.slave),
        .dma     (dma_bus.slave),
        .dcache  (cache_bus.master),
        .gnt_lsu (gnt_lsu),
        .gnt_dma (gnt_dma)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lsu_bus.read_mem = 0; lsu_bus.write_mem = 0; lsu_bus.addr = '0;
        lsu_bus.addr_valid = 0; lsu_bus.write_data = '0; lsu_bus.write_data_valid = 0;
        dma_bus.read_mem = 0; dma_bus.write_mem = 0; dma_bus.addr = '0;
        dma_bus.addr_valid = 0; dma_bus.write_data = '0; dma_bus.write_data_valid = 0;
        cache_bus.mem_done = 0; cache_bus.rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        step(); step();
        vectors++;
        if ({cache_bus.read_mem, cache_bus.write_mem, cache_bus.addr_valid, cache_bus.write_data_valid,
             gnt_lsu, gnt_dma, lsu_bus.mem_done, dma_bus.mem_done} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 00000000", {cache_bus.read_mem, cache_bus.write_mem,
                     cache_bus.addr_valid, cache_bus.write_data_valid, gnt_lsu, gnt_dma,
                     lsu_bus.mem_done, dma_bus.mem_done});
        end
        vectors++;
        if ({cache_bus.addr, cache_bus.write_data, lsu_bus.rdata, dma_bus.rdata} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wdata=%h lrd=%h drd=%h required all 0",
                     cache_bus.addr, cache_bus.write_data, lsu_bus.rdata, dma_bus.rdata);
        end
        vectors++;
        if (dut.starve_cnt_reg !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_starve: got %0d required 0", dut.starve_cnt_reg);
        end
        rst_n = 1;
        step();
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_lsu_read();
        lsu_bus.read_mem = 1; lsu_bus.addr_valid = 1; lsu_bus.addr = 32'h100;
        for (int c = 1; c <= 3; c++) begin
            step();
            vectors++;
            if ({cache_bus.read_mem, cache_bus.write_mem, cache_bus.addr_valid, gnt_lsu, gnt_dma} !== 5'b10110) begin
                miscompares++;
                $display("FAIL t1_ctrl_c%0d: got %b required 10110", c,
                         {cache_bus.read_mem, cache_bus.write_mem, cache_bus.addr_valid, gnt_lsu, gnt_dma});
            end
            vectors++;
            if (cache_bus.addr !== 32'h100) begin
                miscompares++;
                $display("FAIL t1_addr_c%0d: got %h required 00000100", c, cache_bus.addr);
            end
            if (c < 3) begin
                vectors++;
                if (lsu_bus.mem_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL t1_early_done_c%0d: got %b required 0", c, lsu_bus.mem_done);
                end
            end
        end
        cache_bus.mem_done = 1; cache_bus.rdata = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({lsu_bus.mem_done, dma_bus.mem_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL t1_done: got lsu/dma %b required 10", {lsu_bus.mem_done, dma_bus.mem_done});
        end
        vectors++;
        if (lsu_bus.rdata !== 32'hDEADBEEF || dma_bus.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL t1_rdata: got lsu %h dma %h required deadbeef 00000000", lsu_bus.rdata, dma_bus.rdata);
        end
        step();
        cache_bus.mem_done = 0; cache_bus.rdata = '0;
        lsu_bus.read_mem = 0; lsu_bus.addr_valid = 0;
        vectors++;
        if ({cache_bus.read_mem, cache_bus.addr_valid, gnt_lsu, lsu_bus.mem_done} !== 4'b0000 ||
            lsu_bus.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL t1_idle_after: got %b rdata %h required 0000 00000000",
                     {cache_bus.read_mem, cache_bus.addr_valid, gnt_lsu, lsu_bus.mem_done}, lsu_bus.rdata);
        end
        step();
        $display("txn lsu_read addr=00000100 rdata=deadbeef");
    endtask

    task automatic test_starvation();
        logic [4:0] exp_dma  = 5'b10000;
        logic [2:0] exp_cnt;
        lsu_bus.read_mem = 1; lsu_bus.addr_valid = 1; lsu_bus.addr = 32'h40;
        dma_bus.read_mem = 1; dma_bus.addr_valid = 1; dma_bus.addr = 32'h3000;
        for (int k = 0; k < 5; k++) begin
            step();
            exp_cnt = (k < 4) ? 3'(k + 1) : 3'd0;
            vectors++;
            if ({gnt_lsu, gnt_dma} !== {~exp_dma[k], exp_dma[k]}) begin
                miscompares++;
                $display("FAIL t2_grant_%0d: got lsu/dma %b required %b", k, {gnt_lsu, gnt_dma},
                         {~exp_dma[k], exp_dma[k]});
            end
            vectors++;
            if (dut.starve_cnt_reg !== exp_cnt) begin
                miscompares++;
                $display("FAIL t2_starve_%0d: got %0d required %0d", k, dut.starve_cnt_reg, exp_cnt);
            end
            cache_bus.mem_done = 1; cache_bus.rdata = 32'hA0 + k;
            #1;
            vectors++;
            if ({lsu_bus.mem_done, dma_bus.mem_done} !== {~exp_dma[k], exp_dma[k]}) begin
                miscompares++;
                $display("FAIL t2_done_%0d: got lsu/dma %b required %b", k,
                         {lsu_bus.mem_done, dma_bus.mem_done}, {~exp_dma[k], exp_dma[k]});
            end
            step();
            cache_bus.mem_done = 0; cache_bus.rdata = '0;
            vectors++;
            if ({gnt_lsu, gnt_dma, cache_bus.read_mem} !== 3'b000) begin
                miscompares++;
                $display("FAIL t2_idle_%0d: got %b required 000", k, {gnt_lsu, gnt_dma, cache_bus.read_mem});
            end
            $display("txn contested grant %0d to %s", k, exp_dma[k] ? "dma" : "lsu");
        end
        clear_inputs();
        step();
    endtask

    task automatic test_write_gating();
        dma_bus.write_mem = 1; dma_bus.addr_valid = 1; dma_bus.addr = 32'h2000;
        dma_bus.write_data = 32'h1234; dma_bus.write_data_valid = 0;
        step(); step();
        vectors++;
        if ({gnt_dma, cache_bus.write_mem, cache_bus.addr_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL t3_no_grant: got %b required 000", {gnt_dma, cache_bus.write_mem, cache_bus.addr_valid});
        end
        dma_bus.write_data_valid = 1;
        step();
        vectors++;
        if ({gnt_dma, cache_bus.write_mem, cache_bus.read_mem, cache_bus.write_data_valid} !== 4'b1101) begin
            miscompares++;
            $display("FAIL t3_write_ctrl: got %b required 1101",
                     {gnt_dma, cache_bus.write_mem, cache_bus.read_mem, cache_bus.write_data_valid});
        end
        vectors++;
        if (cache_bus.write_data !== 32'h1234 || cache_bus.addr !== 32'h2000) begin
            miscompares++;
            $display("FAIL t3_write_bus: got data %h addr %h required 00001234 00002000",
                     cache_bus.write_data, cache_bus.addr);
        end
        cache_bus.mem_done = 1; cache_bus.rdata = 32'h55;
        #1;
        vectors++;
        if ({lsu_bus.mem_done, dma_bus.mem_done} !== 2'b01 || dma_bus.rdata !== 32'h55) begin
            miscompares++;
            $display("FAIL t3_done: got lsu/dma %b rdata %h required 01 00000055",
                     {lsu_bus.mem_done, dma_bus.mem_done}, dma_bus.rdata);
        end
        step();
        clear_inputs();
        step();
        $display("txn dma_write addr=00002000 data=00001234");
    endtask

    task automatic test_addr_hold();
        lsu_bus.read_mem = 1; lsu_bus.addr_valid = 1; lsu_bus.addr = 32'h100;
        step();
        lsu_bus.addr = 32'h200;
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (cache_bus.addr !== 32'h100) begin
                miscompares++;
                $display("FAIL t4_addr_hold_%0d: got %h required 00000100", c, cache_bus.addr);
            end
        end
        cache_bus.mem_done = 1; cache_bus.rdata = 32'h77;
        #1;
        vectors++;
        if (cache_bus.addr !== 32'h100 || lsu_bus.mem_done !== 1'b1) begin
            miscompares++;
            $display("FAIL t4_done: got addr %h done %b required 00000100 1", cache_bus.addr, lsu_bus.mem_done);
        end
        step();
        clear_inputs();
        step();
        $display("txn lsu_read addr held at 00000100");
    endtask

    task automatic test_reset_busy();
        dma_bus.read_mem = 1; dma_bus.addr_valid = 1; dma_bus.addr = 32'h3300;
        step();
        vectors++;
        if (gnt_dma !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_grant: got %b required 1", gnt_dma);
        end
        rst_n = 0;
        step();
        vectors++;
        if ({gnt_lsu, gnt_dma, cache_bus.read_mem, cache_bus.addr_valid} !== 4'b0000 || cache_bus.addr !== 32'h0) begin
            miscompares++;
            $display("FAIL t5_reset: got %b addr %h required 0000 00000000",
                     {gnt_lsu, gnt_dma, cache_bus.read_mem, cache_bus.addr_valid}, cache_bus.addr);
        end
        rst_n = 1;
        clear_inputs();
        step();
        cache_bus.mem_done = 1; cache_bus.rdata = 32'h99;
        #1;
        vectors++;
        if ({lsu_bus.mem_done, dma_bus.mem_done} !== 2'b00 || dma_bus.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL t5_stale_done: got %b rdata %h required 00 00000000",
                     {lsu_bus.mem_done, dma_bus.mem_done}, dma_bus.rdata);
        end
        step();
        clear_inputs();
        $display("txn reset during dma transaction");
    endtask

    task automatic test_spurious_done();
        step();
        cache_bus.mem_done = 1; cache_bus.rdata = 32'hAAAA;
        #1;
        vectors++;
        if ({lsu_bus.mem_done, dma_bus.mem_done} !== 2'b00 || lsu_bus.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL t6_done: got %b rdata %h required 00 00000000",
                     {lsu_bus.mem_done, dma_bus.mem_done}, lsu_bus.rdata);
        end
        step();
        cache_bus.mem_done = 0;
        vectors++;
        if ({gnt_lsu, gnt_dma, cache_bus.addr_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL t6_idle: got %b required 000", {gnt_lsu, gnt_dma, cache_bus.addr_valid});
        end
        $display("txn spurious mem_done ignored");
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_lsu_read();
        test_starvation();
        test_write_gating();
        test_addr_hold();
        test_reset_busy();
        test_spurious_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
